// File: rtl/swap_pkg.sv
// Shared types and constants for the swap-register checker.
package swap_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10
  } state_t;

  // Event codes carried by the single-entry event buffer
  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_NONE   = 2'b00;
  localparam evt_code_t EVT_LOCK   = 2'b01;
  localparam evt_code_t EVT_FAULT  = 2'b10;
  localparam evt_code_t EVT_RELOCK = 2'b11;

  // Match-run counter width; LOCK_CYC is limited to 1..15
  localparam int RUN_W = 4;

endpackage

// File: rtl/swap_checker_if.sv
// Event channel of the swap checker: valid/ready event handshake plus the
// sticky overflow indication that belongs to it.
interface swap_checker_if;
  import swap_pkg::*;

  logic      evt_valid_o;
  evt_code_t evt_code_o;
  logic      evt_ready_i;
  logic      evt_ovf_o;

  // Producer side (the checker)
  modport master (
    output evt_valid_o,
    output evt_code_o,
    output evt_ovf_o,
    input  evt_ready_i
  );

  // Consumer side
  modport slave (
    input  evt_valid_o,
    input  evt_code_o,
    input  evt_ovf_o,
    output evt_ready_i
  );

endinterface

// File: rtl/swap_evt_buf.sv
// Single-entry event register with valid/ready handshake. A push while the
// entry is occupied and not being drained is dropped and flagged sticky.
module swap_evt_buf
  import swap_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      push,
  input  evt_code_t push_code,
  input  logic      ready,
  output logic      valid,
  output evt_code_t code,
  output logic      ovf
);

  logic accept;

  assign accept = valid && ready;

  // Entry register: load on push when empty or draining, drop otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      code  <= EVT_NONE;
      ovf   <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      code  <= EVT_NONE;
      ovf   <= 1'b0;
    end else if (push && (!valid || accept)) begin
      valid <= 1'b1;
      code  <= push_code;
    end else if (push) begin
      ovf   <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
      code  <= EVT_NONE;
    end
  end

endmodule

// File: rtl/swap_checker.sv
// Monitors a two-bit swap-register stage: each enabled cycle the new pair
// must equal the previous pair swapped. Acquires lock after LOCK_CYC
// consecutive matches, then counts matches and mismatches while tracking.
module swap_checker
  import swap_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic             locked_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] swap_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  swap_checker_if.master   evt
);

  state_t           state_q, state_d;
  logic             pa_p0, pb_p0;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fault_q, fault_d;
  logic             match;
  logic             push;
  evt_code_t        push_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign match   = (a_i == pb_p0) && (b_i == pa_p0);
  assign run_inc = run_q + RUN_W'(1);

  // Previous-pair register, loaded every enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_p0 <= 1'b0;
      pb_p0 <= 1'b0;
    end else if (clr_i) begin
      pa_p0 <= 1'b0;
      pb_p0 <= 1'b0;
    end else if (en_i) begin
      pa_p0 <= a_i;
      pb_p0 <= b_i;
    end
  end

  // Next-state, counter update and event generation
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    swap_cnt_d = swap_cnt_q;
    err_cnt_d  = err_cnt_q;
    fault_d    = fault_q;
    push       = 1'b0;
    push_code  = EVT_NONE;
    if (clr_i) begin
      state_d    = ST_IDLE;
      run_d      = '0;
      swap_cnt_d = '0;
      err_cnt_d  = '0;
      fault_d    = 1'b0;
    end else if (!en_i) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
        ST_ACQ: begin
          if (!match) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(LOCK_CYC)) begin
            state_d   = ST_TRACK;
            run_d     = '0;
            push      = 1'b1;
            push_code = fault_q ? EVT_RELOCK : EVT_LOCK;
          end else begin
            run_d = run_inc;
          end
        end
        ST_TRACK: begin
          if (match) begin
            swap_cnt_d = sat_inc(swap_cnt_q);
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
            fault_d   = 1'b1;
            state_d   = ST_ACQ;
            run_d     = '0;
            push      = 1'b1;
            push_code = EVT_FAULT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Control state, counters and sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      run_q      <= '0;
      swap_cnt_q <= '0;
      err_cnt_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      swap_cnt_q <= swap_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign locked_o   = (state_q == ST_TRACK);
  assign fault_o    = fault_q;
  assign swap_cnt_o = swap_cnt_q;
  assign err_cnt_o  = err_cnt_q;

  swap_evt_buf u_evt_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_i),
    .push      (push),
    .push_code (push_code),
    .ready     (evt.evt_ready_i),
    .valid     (evt.evt_valid_o),
    .code      (evt.evt_code_o),
    .ovf       (evt.evt_ovf_o)
  );

endmodule

// File: tb/tb_swap_checker.sv
// Directed bench for swap_checker: lock acquisition, fault/relock events,
// event buffer overflow and reload, clear priority, enable drop,
// asynchronous reset and counter saturation (narrow-counter instance).
module tb_swap_checker;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic        clr_i;
  logic        a_i;
  logic        b_i;
  logic        locked_o, fault_o;
  logic [15:0] swap_cnt_o, err_cnt_o;
  logic        locked_s, fault_s;
  logic [3:0]  swap_cnt_s, err_cnt_s;

  int n_chk;
  int n_fail;

  swap_checker_if ev ();
  swap_checker_if ev_s ();

  swap_checker #(.CNT_W(16), .LOCK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .locked_o   (locked_o),
    .fault_o    (fault_o),
    .swap_cnt_o (swap_cnt_o),
    .err_cnt_o  (err_cnt_o),
    .evt        (ev.master)
  );

  swap_checker #(.CNT_W(4), .LOCK_CYC(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .locked_o   (locked_s),
    .fault_o    (fault_s),
    .swap_cnt_o (swap_cnt_s),
    .err_cnt_o  (err_cnt_s),
    .evt        (ev_s.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a pair for one clock, return 1 time unit after the edge
  task automatic cyc(input logic a, input logic b);
    a_i = a;
    b_i = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en_i   = 1'b0;
    clr_i  = 1'b0;
    a_i    = 1'b0;
    b_i    = 1'b0;
    ev.evt_ready_i   = 1'b0;
    ev_s.evt_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_swap", swap_cnt_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_valid", ev.evt_valid_o, 0);
    check("rst_code", ev.evt_code_o, 0);
    check("rst_ovf", ev.evt_ovf_o, 0);
    rst_n = 1'b1;
    cyc(0, 0);
    check("idle_valid", ev.evt_valid_o, 0);

    // Acquire lock with alternating pairs, consumer not ready
    en_i = 1'b1;
    cyc(1, 0);
    check("acq1_locked", locked_o, 0);
    cyc(0, 1);
    check("acq2_locked", locked_o, 0);
    check("acq2_valid", ev.evt_valid_o, 0);
    cyc(1, 0);
    check("lock_locked", locked_o, 1);
    check("lock_valid", ev.evt_valid_o, 1);
    check("lock_code", ev.evt_code_o, 2'b01);
    check("lock_swap", swap_cnt_o, 0);
    cyc(0, 1);
    check("trk_swap1", swap_cnt_o, 1);
    cyc(1, 0);
    check("trk_swap2", swap_cnt_o, 2);

    // Mismatch (10 after 10) while the LOCK event is still pending
    cyc(1, 0);
    check("flt_err", err_cnt_o, 1);
    check("flt_fault", fault_o, 1);
    check("flt_locked", locked_o, 0);
    check("flt_code_held", ev.evt_code_o, 2'b01);
    check("flt_ovf", ev.evt_ovf_o, 1);
    check("flt_swap_hold", swap_cnt_o, 2);

    // Relock; consumer accepts in the same cycle the RELOCK is pushed
    cyc(0, 1);
    check("racq_locked", locked_o, 0);
    ev.evt_ready_i = 1'b1;
    cyc(1, 0);
    check("relock_locked", locked_o, 1);
    check("relock_valid", ev.evt_valid_o, 1);
    check("relock_code", ev.evt_code_o, 2'b11);
    cyc(0, 1);
    check("pop_valid", ev.evt_valid_o, 0);
    check("pop_code", ev.evt_code_o, 0);
    check("pop_swap", swap_cnt_o, 3);
    cyc(1, 0);
    check("trk_swap4", swap_cnt_o, 4);

    // Mismatch with empty buffer produces a FAULT event
    cyc(1, 0);
    check("flt2_err", err_cnt_o, 2);
    check("flt2_code", ev.evt_code_o, 2'b10);
    check("flt2_valid", ev.evt_valid_o, 1);
    check("flt2_locked", locked_o, 0);
    check("flt2_ovf_sticky", ev.evt_ovf_o, 1);

    // Back to TRACK, then clear together with a mismatch
    cyc(0, 1);
    check("racq2_valid", ev.evt_valid_o, 0);
    cyc(1, 0);
    check("relock2_code", ev.evt_code_o, 2'b11);
    cyc(0, 1);
    check("trk_swap5", swap_cnt_o, 5);
    clr_i = 1'b1;
    cyc(0, 1);
    clr_i = 1'b0;
    check("clr_locked", locked_o, 0);
    check("clr_swap", swap_cnt_o, 0);
    check("clr_err", err_cnt_o, 0);
    check("clr_fault", fault_o, 0);
    check("clr_ovf", ev.evt_ovf_o, 0);
    check("clr_valid", ev.evt_valid_o, 0);
    check("clr_code", ev.evt_code_o, 0);

    // Re-lock after clear reports LOCK (fault cleared); leave it pending
    ev.evt_ready_i = 1'b0;
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    check("relk_clr_code", ev.evt_code_o, 2'b01);
    check("relk_clr_locked", locked_o, 1);
    cyc(0, 1);
    check("pre_rst_swap", swap_cnt_o, 1);

    // Asynchronous reset mid-TRACK with an event pending
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked", locked_o, 0);
    check("arst_swap", swap_cnt_o, 0);
    check("arst_valid", ev.evt_valid_o, 0);
    check("arst_code", ev.evt_code_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0);
    check("rel1_valid", ev.evt_valid_o, 0);
    check("rel1_locked", locked_o, 0);
    cyc(0, 1);
    check("rel2_valid", ev.evt_valid_o, 0);
    cyc(1, 0);
    check("rel3_code", ev.evt_code_o, 2'b01);
    cyc(0, 1);
    cyc(1, 0);
    check("pre_dis_swap", swap_cnt_o, 2);

    // Disable in TRACK: IDLE, counts hold, no event pushed
    en_i = 1'b0;
    cyc(1, 1);
    check("dis_locked", locked_o, 0);
    check("dis_swap", swap_cnt_o, 2);
    check("dis_code", ev.evt_code_o, 2'b01);
    check("dis_ovf", ev.evt_ovf_o, 0);

    // Long alternating run: narrow counter saturates, wide one keeps counting
    clr_i = 1'b1;
    cyc(0, 0);
    clr_i = 1'b0;
    en_i  = 1'b1;
    ev.evt_ready_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc(((i % 2) == 0), ((i % 2) != 0));
    end
    check("sat_at_max", swap_cnt_s, 4'hF);
    check("wide_at15", swap_cnt_o, 15);
    for (int i = 18; i < 23; i++) begin
      cyc(((i % 2) == 0), ((i % 2) != 0));
    end
    check("sat_no_wrap", swap_cnt_s, 4'hF);
    check("sat_locked", locked_s, 1);
    check("wide_at20", swap_cnt_o, 20);
    check("sat_err", err_cnt_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
